// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with per-channel run enable and a
// valid/ready config port. Each channel emits a registered divided clock and a
// one-cycle tick at the start of every period.
module clk_div_prog #(
   parameter int NUM_CH   = 3,
   parameter int CNT_W    = 32,
   parameter int DEF_DIV  = 50000000,
   parameter int DEF_HIGH = 25000000,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] en_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [CNT_W-1:0]  cfg_div_i,
   input  logic [CNT_W-1:0]  cfg_high_i,
   output logic              cfg_err_o,
   output logic [NUM_CH-1:0] clk_o,
   output logic [NUM_CH-1:0] tick_o
);

   localparam logic [CNT_W-1:0] DEF_DIV_W  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH_W = CNT_W'(DEF_HIGH);

   logic [NUM_CH-1:0] pendVec;
   logic [31:0]       chExt;
   logic              chInRange;
   logic              cfgFire;
   logic              cfgGood;
   logic              err_q;
   logic              err_d;

   // An out-of-range channel has no pending slot, so it is always accepted
   // and then reported as an error.
   always_comb begin
      cfg_ready_o = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cfg_ch_i == CH_W'(c)) begin
            cfg_ready_o = ~pendVec[c];
         end
      end
   end

   assign chExt     = 32'(cfg_ch_i);
   assign chInRange = (chExt < 32'(NUM_CH));
   assign cfgFire   = cfg_valid_i & cfg_ready_o;
   assign cfgGood   = chInRange & (cfg_div_i >= CNT_W'(2)) & (cfg_high_i <= cfg_div_i);
   assign err_d     = cfgFire & ~cfgGood;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign cfg_err_o = err_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_q, div_d;
      logic [CNT_W-1:0] high_q, high_d;
      logic [CNT_W-1:0] pdiv_q, pdiv_d;
      logic [CNT_W-1:0] phigh_q, phigh_d;
      logic             run_q, run_d;
      logic             pend_q, pend_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             accept;
      logic             boundary;
      logic             applyPend;
      logic             applyDirect;

      // A stopped channel takes new settings at once; a running one holds them
      // until the last cycle of the current period (or until it is disabled).
      always_comb begin
         accept      = cfgFire & cfgGood & (cfg_ch_i == CH_W'(c));
         boundary    = run_q & (cnt_q == (div_q - CNT_W'(1)));
         applyPend   = pend_q & (~en_i[c] | boundary);
         applyDirect = accept & ~run_q;

         div_d   = div_q;
         high_d  = high_q;
         pdiv_d  = pdiv_q;
         phigh_d = phigh_q;
         pend_d  = pend_q;

         if (applyDirect) begin
            div_d  = cfg_div_i;
            high_d = cfg_high_i;
         end else if (applyPend) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            pend_d = 1'b0;
         end

         if (accept & run_q) begin
            pend_d  = 1'b1;
            pdiv_d  = cfg_div_i;
            phigh_d = cfg_high_i;
         end

         if (en_i[c]) begin
            cnt_d  = (~run_q | boundary) ? '0 : cnt_q + CNT_W'(1);
            run_d  = 1'b1;
            clk_d  = (cnt_d < high_d);
            tick_d = (cnt_d == '0);
         end else begin
            cnt_d  = '0;
            run_d  = 1'b0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q   <= '0;
            div_q   <= DEF_DIV_W;
            high_q  <= DEF_HIGH_W;
            pdiv_q  <= '0;
            phigh_q <= '0;
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
         end
      end

      assign pendVec[c] = pend_q;
      assign clk_o[c]   = clk_q;
      assign tick_o[c]  = tick_q;
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by random
// traffic, all compared against a period-position reference model.
module tb_clk_div_prog;

   localparam int NUM_CH   = 3;
   localparam int CNT_W    = 8;
   localparam int DEF_DIV  = 4;
   localparam int DEF_HIGH = 2;
   localparam int CH_W     = 2;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [NUM_CH-1:0] en_i;
   logic              cfg_valid_i;
   logic              cfg_ready_o;
   logic [CH_W-1:0]   cfg_ch_i;
   logic [CNT_W-1:0]  cfg_div_i;
   logic [CNT_W-1:0]  cfg_high_i;
   logic              cfg_err_o;
   logic [NUM_CH-1:0] clk_o;
   logic [NUM_CH-1:0] tick_o;

   clk_div_prog #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_ready_o(cfg_ready_o),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_div_i  (cfg_div_i),
      .cfg_high_i (cfg_high_i),
      .cfg_err_o  (cfg_err_o),
      .clk_o      (clk_o),
      .tick_o     (tick_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: where each channel sits inside its current period.
   int mPos   [NUM_CH];
   int mDiv   [NUM_CH];
   int mHigh  [NUM_CH];
   int mPDiv  [NUM_CH];
   int mPHigh [NUM_CH];
   bit mRun   [NUM_CH];
   bit mPend  [NUM_CH];
   bit [NUM_CH-1:0] expClk;
   bit [NUM_CH-1:0] expTick;
   bit expErr;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int c = 0; c < NUM_CH; c++) begin
         mPos[c]  = 0;
         mDiv[c]  = DEF_DIV;
         mHigh[c] = DEF_HIGH;
         mRun[c]  = 1'b0;
         mPend[c] = 1'b0;
      end
      expClk  = '0;
      expTick = '0;
      expErr  = 1'b0;
   endtask

   function automatic bit modelReady(input int ch);
      return (ch >= NUM_CH) ? 1'b1 : !mPend[ch];
   endfunction

   task automatic modelStep(input bit r, input bit [NUM_CH-1:0] en, input bit v,
                            input int ch, input int d, input int h);
      bit fire, good, acc;
      if (r) begin
         modelReset();
         return;
      end
      fire   = v && modelReady(ch);
      good   = (ch < NUM_CH) && (d >= 2) && (h <= d);
      expErr = fire && !good;
      for (int c = 0; c < NUM_CH; c++) begin
         acc = fire && good && (ch == c);
         if (en[c]) begin
            if (!mRun[c] || mPos[c] == mDiv[c] - 1) begin
               if (acc && !mRun[c]) begin
                  mDiv[c] = d;  mHigh[c] = h;
               end else if (mRun[c] && mPend[c]) begin
                  mDiv[c] = mPDiv[c];  mHigh[c] = mPHigh[c];  mPend[c] = 1'b0;
               end
               mPos[c] = 0;
            end else begin
               mPos[c] = mPos[c] + 1;
            end
            if (acc && mRun[c]) begin
               mPend[c] = 1'b1;  mPDiv[c] = d;  mPHigh[c] = h;
            end
            mRun[c]     = 1'b1;
            expClk[c]   = (mPos[c] < mHigh[c]);
            expTick[c]  = (mPos[c] == 0);
         end else begin
            if (mPend[c]) begin
               mDiv[c] = mPDiv[c];  mHigh[c] = mPHigh[c];  mPend[c] = 1'b0;
            end
            if (acc && !mRun[c]) begin
               mDiv[c] = d;  mHigh[c] = h;
            end else if (acc) begin
               mPend[c] = 1'b1;  mPDiv[c] = d;  mPHigh[c] = h;
            end
            mRun[c]    = 1'b0;
            mPos[c]    = 0;
            expClk[c]  = 1'b0;
            expTick[c] = 1'b0;
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, check ready combinationally,
   // then check registered outputs just after the rising edge.
   task automatic applyStimulus(input bit r, input bit [NUM_CH-1:0] en, input bit v,
                                input int ch, input int d, input int h);
      rst_i       = r;
      en_i        = en;
      cfg_valid_i = v;
      cfg_ch_i    = CH_W'(ch);
      cfg_div_i   = CNT_W'(d);
      cfg_high_i  = CNT_W'(h);
      #1;
      checkOutput("cfg_ready", 32'(cfg_ready_o), 32'(modelReady(ch)));
      modelStep(r, en, v, ch, d, h);
      @(posedge clk);
      #1;
      checkOutput("clk_o", 32'(clk_o), 32'(expClk));
      checkOutput("tick_o", 32'(tick_o), 32'(expTick));
      checkOutput("cfg_err", 32'(cfg_err_o), 32'(expErr));
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit [NUM_CH-1:0] en);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, en, 1'b0, i % 4, 0, 0);
      end
   endtask

   initial begin
      rst_i       = 1'b1;
      en_i        = '0;
      cfg_valid_i = 1'b0;
      cfg_ch_i    = '0;
      cfg_div_i   = '0;
      cfg_high_i  = '0;
      modelReset();
      @(negedge clk);

      applyStimulus(1'b1, 3'b000, 1'b0, 0, 0, 0);
      applyStimulus(1'b1, 3'b000, 1'b0, 0, 0, 0);
      checkOutput("reset_clk", 32'(clk_o), 32'd0);
      checkOutput("reset_tick", 32'(tick_o), 32'd0);
      idle(2, 3'b000);

      // Default 4-cycle period, 2 high, ticks on every period start.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 3'b111, 1'b0, 0, 0, 0);
         checkOutput("t1_clk0", 32'(clk_o[0]), ((i % 4) < 2) ? 32'd1 : 32'd0);
         checkOutput("t1_tick", 32'(tick_o), ((i % 4) == 0) ? 32'd7 : 32'd0);
      end

      // Mid-period reconfiguration of ch1.
      idle(2, 3'b111);
      applyStimulus(1'b0, 3'b111, 1'b1, 1, 5, 1);
      applyStimulus(1'b0, 3'b111, 1'b0, 1, 0, 0);
      checkOutput("t2_ready_low", 32'(cfg_ready_o), 32'd0);
      idle(16, 3'b111);

      // Rejected requests.
      applyStimulus(1'b0, 3'b111, 1'b1, 0, 1, 0);
      checkOutput("t3_err_div1", 32'(cfg_err_o), 32'd1);
      idle(1, 3'b111);
      applyStimulus(1'b0, 3'b111, 1'b1, 0, 5, 6);
      checkOutput("t3_err_high", 32'(cfg_err_o), 32'd1);
      idle(1, 3'b111);
      applyStimulus(1'b0, 3'b111, 1'b1, 3, 4, 2);
      checkOutput("t3_err_ch", 32'(cfg_err_o), 32'd1);
      idle(6, 3'b111);

      // Degenerate duty: constant low, then constant high.
      applyStimulus(1'b0, 3'b111, 1'b1, 0, 4, 0);
      idle(10, 3'b111);
      applyStimulus(1'b0, 3'b111, 1'b1, 0, 4, 4);
      idle(10, 3'b111);

      // Pause ch2 and restart it.
      idle(3, 3'b011);
      applyStimulus(1'b0, 3'b111, 1'b0, 0, 0, 0);
      checkOutput("t5_restart_tick2", 32'(tick_o[2]), 32'd1);
      idle(8, 3'b111);

      // Reset with a config pending on ch0.
      applyStimulus(1'b0, 3'b111, 1'b1, 0, 6, 3);
      applyStimulus(1'b1, 3'b111, 1'b0, 0, 0, 0);
      checkOutput("t6_rst_clk", 32'(clk_o), 32'd0);
      idle(12, 3'b111);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit [NUM_CH-1:0] en;
         for (int c = 0; c < NUM_CH; c++) begin
            en[c] = ($urandom_range(0, 9) != 0);
         end
         applyStimulus(($urandom_range(0, 199) == 0), en,
                       ($urandom_range(0, 3) == 0),
                       int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 10)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
